// File: rtl/sdram_bank_scheduler.sv
// Upstream scheduler for two interleaved SDRAM bank controllers: per-bank request FIFOs,
// one issue per bank per 8-cycle period, and tagged read returns in per-bank issue order.
module sdram_bank_scheduler #(
  parameter int ADDR_DEPTH = 23,
  parameter int QDEPTH     = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_DEPTH:0]   req_addr,
  input  logic [7:0]            req_wdata,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic                  hold,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_bank,
  output logic [2:0]            cycle,
  output logic                  bank_en,
  output logic [ADDR_DEPTH-1:0] b0_addr,
  output logic                  b0_rd,
  output logic                  b0_wr,
  output logic [7:0]            b0_wdata,
  input  logic [7:0]            b0_rdata,
  output logic [ADDR_DEPTH-1:0] b1_addr,
  output logic                  b1_rd,
  output logic                  b1_wr,
  output logic [7:0]            b1_wdata,
  input  logic [7:0]            b1_rdata,
  output logic                  idle
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_DEPTH-1:0] addr;
    logic [7:0]            wdata;
    logic [TAG_W-1:0]      tag;
  } entry_t;

  entry_t                fifo_mem [2][QDEPTH];
  logic [PW-1:0]         wr_ptr   [2];
  logic [PW-1:0]         rd_ptr   [2];
  logic [CW-1:0]         count    [2];
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            empty;
  logic                  sel;
  entry_t                entry_in;

  logic [ADDR_DEPTH-1:0] iss_addr  [2];
  logic [7:0]            iss_wdata [2];
  logic [TAG_W-1:0]      iss_tag   [2];
  logic [1:0]            iss_rd;
  logic [1:0]            iss_wr;

  logic [1:0]            p0_rd;
  logic [1:0]            p1_rd;
  logic [TAG_W-1:0]      p0_tag [2];
  logic [TAG_W-1:0]      p1_tag [2];

  assign sel      = req_addr[ADDR_DEPTH];
  assign entry_in = {req_wr, req_addr[ADDR_DEPTH-1:0], req_wdata, req_tag};

  // Ready looks only at the addressed bank's occupancy, before any same-cycle pop.
  assign req_ready = (count[sel] != CW'(QDEPTH));

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      empty[b] = (count[b] == '0);
      push[b]  = req_valid && req_ready && (sel == b[0]);
      pop[b]   = (cycle == 3'd6) && !hold && !empty[b];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (push[b]) fifo_mem[b][wr_ptr[b]] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle     <= '0;
      bank_en   <= 1'b0;
      iss_rd    <= '0;
      iss_wr    <= '0;
      p0_rd     <= '0;
      p1_rd     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_bank  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        wr_ptr[b]    <= '0;
        rd_ptr[b]    <= '0;
        count[b]     <= '0;
        iss_addr[b]  <= '0;
        iss_wdata[b] <= '0;
        iss_tag[b]   <= '0;
        p0_tag[b]    <= '0;
        p1_tag[b]    <= '0;
      end
    end else begin
      cycle     <= cycle + 3'd1;
      bank_en   <= 1'b1;
      rsp_valid <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        if (push[b]) wr_ptr[b] <= wr_ptr[b] + PW'(1);
        if (pop[b])  rd_ptr[b] <= rd_ptr[b] + PW'(1);
        if (push[b] && !pop[b])      count[b] <= count[b] + CW'(1);
        else if (pop[b] && !push[b]) count[b] <= count[b] - CW'(1);

        if (cycle == 3'd6) begin
          if (pop[b]) begin
            iss_addr[b]  <= fifo_mem[b][rd_ptr[b]].addr;
            iss_wdata[b] <= fifo_mem[b][rd_ptr[b]].wdata;
            iss_tag[b]   <= fifo_mem[b][rd_ptr[b]].tag;
            iss_rd[b]    <= !fifo_mem[b][rd_ptr[b]].wr;
            iss_wr[b]    <= fifo_mem[b][rd_ptr[b]].wr;
          end else begin
            iss_rd[b] <= 1'b0;
            iss_wr[b] <= 1'b0;
          end
        end else if (cycle == 3'd7) begin
          // Strobes drop as the op enters the in-flight pipe; writes travel as rd=0.
          iss_rd[b] <= 1'b0;
          iss_wr[b] <= 1'b0;
          p0_rd[b]  <= iss_rd[b];
          p0_tag[b] <= iss_tag[b];
          p1_rd[b]  <= p0_rd[b];
          p1_tag[b] <= p0_tag[b];
        end
      end

      // Bank data for a read issued two periods back is stable for the whole period.
      if (cycle == 3'd0 && p1_rd[0]) begin
        rsp_valid <= 1'b1;
        rsp_data  <= b0_rdata;
        rsp_tag   <= p1_tag[0];
        rsp_bank  <= 1'b0;
      end
      if (cycle == 3'd1 && p1_rd[1]) begin
        rsp_valid <= 1'b1;
        rsp_data  <= b1_rdata;
        rsp_tag   <= p1_tag[1];
        rsp_bank  <= 1'b1;
      end
    end
  end

  assign b0_addr  = iss_addr[0];
  assign b0_rd    = iss_rd[0];
  assign b0_wr    = iss_wr[0];
  assign b0_wdata = iss_wdata[0];
  assign b1_addr  = iss_addr[1];
  assign b1_rd    = iss_rd[1];
  assign b1_wr    = iss_wr[1];
  assign b1_wdata = iss_wdata[1];

  assign idle = bank_en && (empty == 2'b11) && (p0_rd == 2'b00) && (p1_rd == 2'b00)
                && (iss_rd == 2'b00) && (iss_wr == 2'b00);

endmodule

// File: tb/tb_sdram_bank_scheduler.sv
// Bench for sdram_bank_scheduler: queue-based reference model, bank device model with
// two-period read latency, and a response scoreboard checked by a separate monitor.
module tb_sdram_bank_scheduler;
  localparam int AD = 23;
  localparam int QD = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_wr, hold;
  logic [AD:0]   req_addr;
  logic [7:0]    req_wdata;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_bank, bank_en, idle;
  logic [7:0]    rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    cycle;
  logic [AD-1:0] b0_addr, b1_addr;
  logic          b0_rd, b0_wr, b1_rd, b1_wr;
  logic [7:0]    b0_wdata, b1_wdata, b0_rdata, b1_rdata;

  always #5 clk = ~clk;

  sdram_bank_scheduler #(.ADDR_DEPTH(AD), .QDEPTH(QD), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag), .hold(hold),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_bank(rsp_bank),
    .cycle(cycle), .bank_en(bank_en),
    .b0_addr(b0_addr), .b0_rd(b0_rd), .b0_wr(b0_wr), .b0_wdata(b0_wdata), .b0_rdata(b0_rdata),
    .b1_addr(b1_addr), .b1_rd(b1_rd), .b1_wr(b1_wr), .b1_wdata(b1_wdata), .b1_rdata(b1_rdata),
    .idle(idle));

  typedef struct {
    bit          wr;
    int          addr;
    logic [7:0]  wdata;
    logic [3:0]  tag;
    logic [7:0]  data;
  } req_t;
  typedef struct {
    logic [3:0] tag;
    logic [7:0] data;
    int         period;
  } rsp_t;
  typedef struct {
    int         period;
    logic [7:0] data;
  } pend_t;

  req_t       q     [2][$];
  rsp_t       rsp_q [2][$];
  pend_t      pend  [2][$];
  req_t       iss   [2];
  bit         iss_v [2];
  logic [7:0] smem  [2][512];
  logic [7:0] dmem  [2][512];

  int checks = 0;
  int errors = 0;
  int tcyc, tper, nedge;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] dflt(int b, int a);
    return 8'((a * 7) + (b * 91) + 3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcyc = 0; tper = 0; nedge = 0;
    end else begin
      nedge++;
      if (tcyc == 7) begin tcyc = 0; tper++; end
      else tcyc++;
    end
  end

  // Reference model and bank devices, evaluated mid low-phase.
  always @(negedge clk) begin
    int sb;
    bit rdy;
    logic rd_a, wr_a;
    logic [AD-1:0] ad;
    logic [7:0] wd;
    req_t r;
    rsp_t x;
    pend_t p;
    #2;
    if (rst_n) begin
      chk("cycle", cycle, tcyc);
      chk("bank_en", bank_en, nedge >= 1);
      for (int b = 0; b < 2; b++) begin
        rd_a = b ? b1_rd : b0_rd;
        wr_a = b ? b1_wr : b0_wr;
        ad   = b ? b1_addr : b0_addr;
        wd   = b ? b1_wdata : b0_wdata;
        if (tcyc == 7) begin
          chk($sformatf("b%0d_rd", b), rd_a, iss_v[b] && !iss[b].wr);
          chk($sformatf("b%0d_wr", b), wr_a, iss_v[b] && iss[b].wr);
          if (iss_v[b]) begin
            chk($sformatf("b%0d_addr", b), ad, iss[b].addr);
            if (iss[b].wr) chk($sformatf("b%0d_wdata", b), wd, iss[b].wdata);
          end
          if (wr_a === 1'b1) dmem[b][ad[8:0]] = wd;
          if (rd_a === 1'b1) begin
            p.period = tper + 2; p.data = dmem[b][ad[8:0]];
            pend[b].push_back(p);
          end
        end else begin
          chk($sformatf("b%0d_strobe_off", b), {rd_a, wr_a}, 0);
        end
      end
      if (tcyc == 0) begin
        if (pend[0].size() > 0 && pend[0][0].period == tper) b0_rdata = pend[0].pop_front().data;
        else b0_rdata = 8'($urandom);
        if (pend[1].size() > 0 && pend[1][0].period == tper) b1_rdata = pend[1].pop_front().data;
        else b1_rdata = 8'($urandom);
      end
      sb  = int'(req_addr[AD]);
      rdy = q[sb].size() < QD;
      chk("req_ready", req_ready, rdy);
      if (q[0].size() + q[1].size() > 0) chk("idle_busy", idle, 0);
      if (tcyc == 6) begin
        for (int b = 0; b < 2; b++) begin
          iss_v[b] = (q[b].size() > 0) && !hold;
          if (iss_v[b]) begin
            iss[b] = q[b].pop_front();
            if (!iss[b].wr) begin
              x.tag = iss[b].tag; x.data = iss[b].data; x.period = tper + 2;
              rsp_q[b].push_back(x);
            end
          end
        end
      end
      if (req_valid && rdy) begin
        r.wr = req_wr; r.addr = int'(req_addr[AD-1:0]); r.wdata = req_wdata; r.tag = req_tag;
        if (r.wr) smem[sb][r.addr[8:0]] = r.wdata;
        r.data = smem[sb][r.addr[8:0]];
        q[sb].push_back(r);
      end
    end
  end

  // Response monitor: bank 0 answers in cycle 1, bank 1 in cycle 2, two periods after issue.
  always @(negedge clk) begin
    int b;
    bit e;
    rsp_t x;
    #2;
    if (rst_n) begin
      if (tcyc == 1 || tcyc == 2) begin
        b = tcyc - 1;
        e = rsp_q[b].size() > 0 && rsp_q[b][0].period == tper;
        chk($sformatf("rsp_valid_c%0d", tcyc), rsp_valid, e);
        if (e) begin
          x = rsp_q[b].pop_front();
          chk("rsp_bank", rsp_bank, b);
          chk("rsp_tag", rsp_tag, x.tag);
          chk("rsp_data", rsp_data, x.data);
        end
      end else begin
        chk("rsp_valid_off", rsp_valid, 0);
      end
    end
  end

  task automatic drive(bit v, bit wr, bit b, int a, logic [7:0] d, logic [3:0] t);
    req_valid = v; req_wr = wr; req_addr = {b, AD'(a)}; req_wdata = d; req_tag = t;
  endtask

  task automatic push(bit wr, bit b, int a, logic [7:0] d, logic [3:0] t);
    int n = 0;
    @(negedge clk); drive(1'b1, wr, b, a, d, t);
    #1;
    while (!req_ready && n < 64) begin @(negedge clk); #1; n++; end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic quiet(int k);
    repeat (k) begin @(negedge clk); req_valid = 1'b0; end
  endtask

  task automatic align(int c);
    int n = 0;
    @(negedge clk); req_valid = 1'b0;
    while (tcyc != c && n < 16) begin @(negedge clk); req_valid = 1'b0; n++; end
  endtask

  task automatic preset(int b, int a, logic [7:0] v);
    smem[b][a] = v; dmem[b][a] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) preset(b, a, dflt(b, a));
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    hold = 1'b0; b0_rdata = 8'h00; b1_rdata = 8'h00;
    for (int b = 0; b < 2; b++) iss_v[b] = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_cycle", cycle, 0);
    chk("rst_bank_en", bank_en, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {b0_rd, b0_wr, b1_rd, b1_wr}, 0);
    chk("rst_idle", idle, 0);

    // First read after reset: accepted at clock 0, response at clock 17.
    preset(0, 'h123, 8'hA5);
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 1'b0, 'h123, 8'h00, 4'd5);
    @(negedge clk); req_valid = 1'b0;
    repeat (15) @(negedge clk);
    #3 chk("lat_clk16_valid", rsp_valid, 0);
    @(negedge clk);
    #3;
    chk("lat_clk17_valid", rsp_valid, 1);
    chk("lat_clk17_data", rsp_data, 8'hA5);
    chk("lat_clk17_tag", rsp_tag, 5);
    chk("lat_clk17_bank", rsp_bank, 0);

    // Same-period reads to both banks.
    align(7);
    push(1'b0, 1'b0, 'h011, 8'h00, 4'd1);
    push(1'b0, 1'b1, 'h022, 8'h00, 4'd2);
    quiet(30);

    // Fill bank 1 past capacity.
    align(7);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 'h10 + i, 8'(8'h80 + i), 4'(i));
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 'h14, 8'h84, 4'd4);
    #1 chk("full_ready", req_ready, 0);
    begin
      int n = 0;
      while (!req_ready && n < 32) begin @(negedge clk); #1; n++; end
    end
    quiet(50);

    // hold across three issue slots with an earlier read already issued.
    align(7);
    push(1'b0, 1'b0, 'h020, 8'h00, 4'd3);
    align(6);
    @(negedge clk); hold = 1'b1;
    push(1'b0, 1'b0, 'h021, 8'h00, 4'd4);
    push(1'b0, 1'b1, 'h030, 8'h00, 4'd6);
    align(7); align(7); align(7);
    hold = 1'b0;
    quiet(32);

    // Write then read of the same address.
    align(7);
    push(1'b1, 1'b0, 'h040, 8'h3C, 4'd0);
    push(1'b0, 1'b0, 'h040, 8'h00, 4'd7);
    quiet(40);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tcyc == 7) hold = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), 8'($urandom), 4'($urandom));
    end
    @(negedge clk); hold = 1'b0;
    quiet(80);
    #2 chk("idle_drained", idle, 1);

    // Reset while two reads are in flight.
    align(7);
    push(1'b0, 1'b0, 'h005, 8'h00, 4'd8);
    push(1'b0, 1'b1, 'h006, 8'h00, 4'd9);
    align(7);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int b = 0; b < 2; b++) begin
      q[b].delete(); rsp_q[b].delete(); pend[b].delete(); iss_v[b] = 1'b0;
    end
    smem = dmem;
    #1;
    chk("mid_rst_cycle", cycle, 0);
    chk("mid_rst_bank_en", bank_en, 0);
    chk("mid_rst_strobes", {b0_rd, b0_wr, b1_rd, b1_wr}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_b0_addr", b0_addr, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet(40);
    #2 chk("idle_after_reset", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
